// File: rtl/bus_register_loader.sv
// Receiving end of the 16-bit common bus: loads, increments and clears the
// architectural registers AR, PC, DR, AC, IR and TR, and runs the RAM
// write handshake for the Memory load bit.
// Optional feature macro: MEM_TIMEOUT_EN (abandons a write after TIMEOUT_CYC
// cycles without mem_ack and pulses mem_timeout).
module bus_register_loader #(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] bus,
    input  logic [7:0]        load,
    input  logic [7:0]        inc,
    input  logic [7:0]        clr,
    input  logic              mem_ack,
    output logic [DATA_W-1:0] AR,
    output logic [DATA_W-1:0] PC,
    output logic [DATA_W-1:0] DR,
    output logic [DATA_W-1:0] AC,
    output logic [DATA_W-1:0] IR,
    output logic [DATA_W-1:0] TR,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic              load_err,
    output logic              mem_timeout
);

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    state_t state, state_n;

    // Index 1..6 follows the bus selection encoding (AR..TR).
    logic [DATA_W-1:0] regs [1:6];

    logic req_any;
    logic expire;

    // Bits with no register behind them are intentionally ignored.
    logic unused_bits;
    assign unused_bits = ^{load[0], inc[0], inc[7], clr[0], clr[7]};

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    logic [CW-1:0] tcnt;

    // Counts cycles spent in WRITE; cleared whenever the FSM is idle.
    always_ff @(posedge CLK) begin
        if (RST || state != WRITE)
            tcnt <= '0;
        else
            tcnt <= tcnt + 1'b1;
    end

    // An ack on the expiry edge completes the write instead of timing out.
    assign expire = (state == WRITE) && !mem_ack && (tcnt == CW'(TIMEOUT_CYC - 1));

    // One-cycle pulse on an abandoned write.
    always_ff @(posedge CLK) begin
        if (RST)
            mem_timeout <= 1'b0;
        else
            mem_timeout <= expire;
    end
`else
    logic [31:0] unused_tmo;
    assign unused_tmo  = 32'(TIMEOUT_CYC);
    assign expire      = 1'b0;
    assign mem_timeout = 1'b0;
`endif

    // Next-state decode for the memory write handshake.
    always_comb begin
        state_n = state;
        req_any = (|load[7:1]) | (|inc[6:1]) | (|clr[6:1]);
        case (state)
            IDLE:    if (load[7]) state_n = WRITE;
            WRITE:   if (mem_ack || expire) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // State register plus write capture and the dropped-request flag.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            mem_addr  <= '0;
            mem_wdata <= '0;
            load_err  <= 1'b0;
        end else begin
            state    <= state_n;
            load_err <= (state == WRITE) && req_any;
            if (state == IDLE && load[7]) begin
                mem_addr  <= regs[1];
                mem_wdata <= bus;
            end
        end
    end

    // Per-register update, clr > load > inc; frozen while a write is outstanding.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int unsigned i = 1; i <= 6; i++)
                regs[i] <= '0;
        end else if (state == IDLE) begin
            for (int unsigned i = 1; i <= 6; i++) begin
                if (clr[i])
                    regs[i] <= '0;
                else if (load[i])
                    regs[i] <= bus;
                else if (inc[i])
                    regs[i] <= regs[i] + 1'b1;
            end
        end
    end

    assign AR     = regs[1];
    assign PC     = regs[2];
    assign DR     = regs[3];
    assign AC     = regs[4];
    assign IR     = regs[5];
    assign TR     = regs[6];
    assign mem_we = (state == WRITE);
    assign busy   = (state == WRITE);

endmodule

// File: tb/tb_bus_register_loader.sv
// Directed bench for bus_register_loader: a vector table for register
// updates and the write handshake, followed by a stalled-write sequence.
module tb_bus_register_loader;

    logic        CLK = 1'b0;
    logic        RST;
    logic [15:0] bus;
    logic [7:0]  load, inc, clr;
    logic        mem_ack;
    logic [15:0] AR, PC, DR, AC, IR, TR, mem_addr, mem_wdata;
    logic        mem_we, busy, load_err, mem_timeout;

    int nvec = 0;
    int nerr = 0;

    bus_register_loader #(.DATA_W(16), .TIMEOUT_CYC(16)) dut (
        .CLK(CLK), .RST(RST), .bus(bus), .load(load), .inc(inc), .clr(clr),
        .mem_ack(mem_ack), .AR(AR), .PC(PC), .DR(DR), .AC(AC), .IR(IR), .TR(TR),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy),
        .load_err(load_err), .mem_timeout(mem_timeout)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        rst;
        logic [15:0] bus;
        logic [7:0]  ld, inc, clr;
        logic        ack;
        logic [15:0] ar, pc, dr, ac, ir, tr, ma, mw;
        logic        we, bsy, err;
    } vec_t;

    vec_t v [20];

    function automatic vec_t mk(input logic rst, input logic [15:0] b, input logic [7:0] ld,
                                input logic [7:0] in, input logic [7:0] cl, input logic ack,
                                input logic [15:0] ar, input logic [15:0] pc, input logic [15:0] dr,
                                input logic [15:0] ac, input logic [15:0] ir, input logic [15:0] tr,
                                input logic [15:0] ma, input logic [15:0] mw,
                                input logic we, input logic bsy, input logic err);
        vec_t r;
        r.rst = rst; r.bus = b; r.ld = ld; r.inc = in; r.clr = cl; r.ack = ack;
        r.ar = ar; r.pc = pc; r.dr = dr; r.ac = ac; r.ir = ir; r.tr = tr;
        r.ma = ma; r.mw = mw; r.we = we; r.bsy = bsy; r.err = err;
        return r;
    endfunction

    task automatic drive(input logic rst, input logic [15:0] b, input logic [7:0] ld,
                         input logic [7:0] in, input logic [7:0] cl, input logic ack);
        @(negedge CLK);
        RST = rst; bus = b; load = ld; inc = in; clr = cl; mem_ack = ack;
        @(posedge CLK);
        #1;
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    initial begin
        logic [131:0] got, exp;

        RST = 1'b1; bus = '0; load = '0; inc = '0; clr = '0; mem_ack = 1'b0;

        //           rst bus      ld     inc    clr    ack AR       PC       DR       AC       IR       TR       maddr    mwdata   we bsy err
        v[0]  = mk(1, 16'h0000, 8'h00, 8'h00, 8'h00, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0);
        v[1]  = mk(1, 16'hFFFF, 8'hFE, 8'hFE, 8'h00, 1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0);
        v[2]  = mk(0, 16'h1234, 8'h0A, 8'h00, 8'h00, 0, 16'h1234, 16'h0000, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0);
        v[3]  = mk(0, 16'hFFFF, 8'h04, 8'h00, 8'h00, 0, 16'h1234, 16'hFFFF, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0);
        v[4]  = mk(0, 16'h0000, 8'h00, 8'h04, 8'h00, 0, 16'h1234, 16'h0000, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0);
        v[5]  = mk(0, 16'h7777, 8'h10, 8'h00, 8'h00, 0, 16'h1234, 16'h0000, 16'h1234, 16'h7777, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0);
        v[6]  = mk(0, 16'h1111, 8'h10, 8'h10, 8'h10, 0, 16'h1234, 16'h0000, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0);
        v[7]  = mk(0, 16'h2222, 8'h00, 8'h10, 8'h00, 0, 16'h1234, 16'h0000, 16'h1234, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0);
        v[8]  = mk(0, 16'h0040, 8'h02, 8'h00, 8'h00, 0, 16'h0040, 16'h0000, 16'h1234, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0);
        v[9]  = mk(0, 16'hBEEF, 8'h82, 8'h00, 8'h00, 0, 16'hBEEF, 16'h0000, 16'h1234, 16'h0001, 16'h0000, 16'h0000, 16'h0040, 16'hBEEF, 1, 1, 0);
        v[10] = mk(0, 16'h5555, 8'h08, 8'h00, 8'h00, 0, 16'hBEEF, 16'h0000, 16'h1234, 16'h0001, 16'h0000, 16'h0000, 16'h0040, 16'hBEEF, 1, 1, 1);
        v[11] = mk(0, 16'h5555, 8'h00, 8'h00, 8'h00, 0, 16'hBEEF, 16'h0000, 16'h1234, 16'h0001, 16'h0000, 16'h0000, 16'h0040, 16'hBEEF, 1, 1, 0);
        v[12] = mk(0, 16'h5555, 8'h08, 8'h00, 8'h00, 1, 16'hBEEF, 16'h0000, 16'h1234, 16'h0001, 16'h0000, 16'h0000, 16'h0040, 16'hBEEF, 0, 0, 1);
        v[13] = mk(0, 16'h5555, 8'h08, 8'h00, 8'h00, 0, 16'hBEEF, 16'h0000, 16'h5555, 16'h0001, 16'h0000, 16'h0000, 16'h0040, 16'hBEEF, 0, 0, 0);
        v[14] = mk(0, 16'h9999, 8'h00, 8'h00, 8'h00, 1, 16'hBEEF, 16'h0000, 16'h5555, 16'h0001, 16'h0000, 16'h0000, 16'h0040, 16'hBEEF, 0, 0, 0);
        v[15] = mk(0, 16'h00A0, 8'h60, 8'h00, 8'h00, 0, 16'hBEEF, 16'h0000, 16'h5555, 16'h0001, 16'h00A0, 16'h00A0, 16'h0040, 16'hBEEF, 0, 0, 0);
        v[16] = mk(0, 16'h0000, 8'h00, 8'h40, 8'h00, 0, 16'hBEEF, 16'h0000, 16'h5555, 16'h0001, 16'h00A0, 16'h00A1, 16'h0040, 16'hBEEF, 0, 0, 0);
        v[17] = mk(0, 16'h0000, 8'h00, 8'h00, 8'h20, 0, 16'hBEEF, 16'h0000, 16'h5555, 16'h0001, 16'h0000, 16'h00A1, 16'h0040, 16'hBEEF, 0, 0, 0);
        v[18] = mk(0, 16'hCAFE, 8'h80, 8'h00, 8'h00, 0, 16'hBEEF, 16'h0000, 16'h5555, 16'h0001, 16'h0000, 16'h00A1, 16'hBEEF, 16'hCAFE, 1, 1, 0);
        v[19] = mk(1, 16'h0000, 8'h00, 8'h00, 8'h00, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0);

        for (int i = 0; i < 20; i++) begin
            drive(v[i].rst, v[i].bus, v[i].ld, v[i].inc, v[i].clr, v[i].ack);
            got = {AR, PC, DR, AC, IR, TR, mem_addr, mem_wdata, mem_we, busy, load_err, mem_timeout};
            exp = {v[i].ar, v[i].pc, v[i].dr, v[i].ac, v[i].ir, v[i].tr, v[i].ma, v[i].mw,
                   v[i].we, v[i].bsy, v[i].err, 1'b0};
            nvec++;
            if (got !== exp) begin
                nerr++;
                $display("FAIL vec%0d: got %h expected %h", i, got, exp);
            end
        end

        // Stalled write: no mem_ack ever arrives.
        drive(0, 16'h1357, 8'h80, 8'h00, 8'h00, 0);
        check1("stall_start_we", mem_we, 1'b1);
`ifdef MEM_TIMEOUT_EN
        for (int c = 1; c < 16; c++) begin
            drive(0, 16'h0000, 8'h00, 8'h00, 8'h00, 0);
            if (c == 8) check1("stall_mid_we", mem_we, 1'b1);
        end
        check1("pre_expiry_we", mem_we, 1'b1);
        check1("pre_expiry_tmo", mem_timeout, 1'b0);
        drive(0, 16'h0000, 8'h00, 8'h00, 8'h00, 0);
        check1("expiry_we", mem_we, 1'b0);
        check1("expiry_tmo", mem_timeout, 1'b1);
        drive(0, 16'h0000, 8'h00, 8'h00, 8'h00, 0);
        check1("post_expiry_tmo", mem_timeout, 1'b0);
        // Ack on the expiry edge completes the write without a timeout pulse.
        drive(0, 16'h2468, 8'h80, 8'h00, 8'h00, 0);
        for (int c = 1; c < 16; c++) drive(0, 16'h0000, 8'h00, 8'h00, 8'h00, 0);
        drive(0, 16'h0000, 8'h00, 8'h00, 8'h00, 1);
        check1("ack_on_expiry_we", mem_we, 1'b0);
        check1("ack_on_expiry_tmo", mem_timeout, 1'b0);
        drive(0, 16'h0000, 8'h00, 8'h00, 8'h00, 0);
        check1("ack_on_expiry_tmo_next", mem_timeout, 1'b0);
        drive(0, 16'h3333, 8'h80, 8'h00, 8'h00, 0);
        check1("restart_we", mem_we, 1'b1);
`else
        for (int c = 1; c <= 100; c++) drive(0, 16'h0000, 8'h00, 8'h00, 8'h00, 0);
        check1("stall_100_we", mem_we, 1'b1);
        check1("stall_100_busy", busy, 1'b1);
        check1("stall_100_tmo", mem_timeout, 1'b0);
`endif
        // Reset in the middle of a write.
        drive(1, 16'h0000, 8'h00, 8'h00, 8'h00, 0);
        check1("rst_mid_we", mem_we, 1'b0);
        check1("rst_mid_busy", busy, 1'b0);
        nvec++;
        if (mem_addr !== 16'h0000) begin
            nerr++;
            $display("FAIL rst_mid_addr: got %h expected 0000", mem_addr);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
